// File: rtl/audio_level_meter.sv
// Peak-envelope audio level meter: 10-step 6 dB/step LED bar graph plus clip indicator.
// Optional peak-hold dot is enabled by defining AUDIO_LEVEL_METER_PEAK_HOLD_EN.
module audio_level_meter #(
    parameter int                DATA_W        = 24,
    parameter int                DECAY_SHIFT   = 4,
    parameter int                DECAY_SAMPLES = 48,
    parameter int                HOLD_SAMPLES  = 24000,
    parameter logic [DATA_W-1:0] CLIP_THRESH   = 24'h7F0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [9:0]        led_red,
    output logic [3:0]        bar_level,
    output logic              clip
);

    localparam int                DCNT_W    = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
    localparam int                HOLD_W    = $clog2(HOLD_SAMPLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
    localparam logic [DATA_W-1:0] MAG_MAX   = {1'b0, {(DATA_W-1){1'b1}}};

    // Absolute value; the most negative code has no positive twin and saturates.
    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] n;
        n = x[DATA_W-1] ? (~x + DATA_W'(1'b1)) : x;
        return n[DATA_W-1] ? MAG_MAX : n;
    endfunction

    // Number of 6 dB thresholds (2^13 .. 2^22) the envelope reaches.
    function automatic logic [3:0] env_level(input logic [DATA_W-1:0] e);
        logic [3:0] l;
        l = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (e >= (DATA_W'(1'b1) << (13 + k))) begin
                l = l + 4'd1;
            end else begin
                l = l;
            end
        end
        return l;
    endfunction

    logic [DATA_W-1:0] mag_r;
    logic              v1_r;
    logic [DATA_W-1:0] env_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic              v2_r;
    logic              clip_r;
    logic [HOLD_W-1:0] clip_cnt_r;
    logic [3:0]        bar_level_r;
    logic [9:0]        led_red_r;

    logic              decay_due_s;
    logic [DATA_W-1:0] env_dec_s;
    logic [3:0]        level_s;
    logic [9:0]        bar_s;
    logic [9:0]        led_nxt_s;

    // Stage 1: capture saturated magnitude of each incoming sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_r <= {DATA_W{1'b0}};
            v1_r  <= 1'b0;
        end else begin
            v1_r <= sample_valid;
            if (sample_valid) begin
                mag_r <= sat_abs(sample_data);
            end else begin
                mag_r <= mag_r;
            end
        end
    end

    // Decay tick decode and the decayed envelope candidate.
    always_comb begin
        decay_due_s = (dcnt_r == DCNT_LAST);
        env_dec_s   = env_r - (env_r >> DECAY_SHIFT);
    end

    // Stage 2: envelope attack/decay, decay sample counter and clip hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            env_r      <= {DATA_W{1'b0}};
            dcnt_r     <= {DCNT_W{1'b0}};
            v2_r       <= 1'b0;
            clip_r     <= 1'b0;
            clip_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                // Attack wins over a coincident decay tick; the counter still wraps.
                if (mag_r > env_r) begin
                    env_r <= mag_r;
                end else if (decay_due_s) begin
                    env_r <= env_dec_s;
                end else begin
                    env_r <= env_r;
                end
                dcnt_r <= decay_due_s ? {DCNT_W{1'b0}} : (dcnt_r + DCNT_W'(1'b1));

                if (mag_r >= CLIP_THRESH) begin
                    clip_r     <= 1'b1;
                    clip_cnt_r <= HOLD_LOAD;
                end else if (clip_cnt_r != {HOLD_W{1'b0}}) begin
                    clip_r     <= (clip_cnt_r != HOLD_W'(1'b1));
                    clip_cnt_r <= clip_cnt_r - HOLD_W'(1'b1);
                end else begin
                    clip_r     <= 1'b0;
                    clip_cnt_r <= clip_cnt_r;
                end
            end else begin
                env_r      <= env_r;
                dcnt_r     <= dcnt_r;
                clip_r     <= clip_r;
                clip_cnt_r <= clip_cnt_r;
            end
        end
    end

    // Stage 3 combinational: bar-graph level and thermometer code.
    always_comb begin
        level_s = env_level(env_r);
        bar_s   = 10'((11'd1 << level_s) - 11'd1);
    end

`ifdef AUDIO_LEVEL_METER_PEAK_HOLD_EN
    logic [3:0]        peak_idx_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [3:0]        peak_nxt_s;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic [9:0]        dot_s;

    // Peak-hold tracking: a higher level or an expired hold retakes the dot.
    always_comb begin
        if ((level_s > peak_idx_r) || (hold_cnt_r == {HOLD_W{1'b0}})) begin
            peak_nxt_s = level_s;
            hold_nxt_s = HOLD_LOAD;
        end else begin
            peak_nxt_s = peak_idx_r;
            hold_nxt_s = hold_cnt_r - HOLD_W'(1'b1);
        end
        if (peak_nxt_s != 4'd0) begin
            dot_s = 10'd1 << (peak_nxt_s - 4'd1);
        end else begin
            dot_s = 10'd0;
        end
        led_nxt_s = bar_s | dot_s;
    end

    // Peak-hold state advances once per stage-2 result.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_idx_r <= 4'd0;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (v2_r) begin
            peak_idx_r <= peak_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end else begin
            peak_idx_r <= peak_idx_r;
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    // Bar graph only.
    always_comb begin
        led_nxt_s = bar_s;
    end
`endif

    // Stage 3 registers: outputs move only after a stage-2 result.
    always_ff @(posedge clk) begin
        if (reset) begin
            bar_level_r <= 4'd0;
            led_red_r   <= 10'h000;
        end else if (v2_r) begin
            bar_level_r <= level_s;
            led_red_r   <= led_nxt_s;
        end else begin
            bar_level_r <= bar_level_r;
            led_red_r   <= led_red_r;
        end
    end

    assign led_red   = led_red_r;
    assign bar_level = bar_level_r;
    assign clip      = clip_r;

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: sample-level behavioural model plus directed literals.
module tb_audio_level_meter;

    localparam int DS = 4;
    localparam int SH = 4;
    localparam int HS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_data = 24'h000000;
    logic [9:0]  led_red;
    logic [3:0]  bar_level;
    logic        clip;

    audio_level_meter #(
        .DATA_W(24), .DECAY_SHIFT(SH), .DECAY_SAMPLES(DS), .HOLD_SAMPLES(HS),
        .CLIP_THRESH(24'h7F0000)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .led_red(led_red), .bar_level(bar_level), .clip(clip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

`ifdef AUDIO_LEVEL_METER_PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    // Model state: envelope, samples since reset, samples since last clip, peak dot.
    int m_env, m_nsamp, m_since, m_pk, m_age;
    bit m_clipped;

    typedef struct { int t; int bar; int led; } bev_t;
    typedef struct { int t; int c; } cev_t;
    bev_t bq[$];
    cev_t cq[$];
    int e_bar = 0, e_led = 0, e_clip = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_sample(input logic [23:0] d, input int n);
        int s, mag, lvl, led, c;
        bev_t be;
        cev_t ce;
        s   = $signed(d);
        mag = (s < 0) ? -s : s;
        if (mag > 24'h7FFFFF) mag = 24'h7FFFFF;
        if (mag >= 24'h7F0000) begin
            m_clipped = 1'b1;
            m_since   = 0;
        end else begin
            m_since++;
        end
        c = (m_clipped && m_since < HS) ? 1 : 0;
        if (mag > m_env) m_env = mag;
        else if (m_nsamp % DS == DS - 1) m_env = m_env - m_env / (1 << SH);
        m_nsamp++;
        lvl = 0;
        for (int k = 0; k < 10; k++) if (m_env >= (1 << (13 + k))) lvl++;
        led = (1 << lvl) - 1;
        if (PEAK) begin
            if (lvl > m_pk || m_age >= HS) begin
                m_pk  = lvl;
                m_age = 0;
            end else begin
                m_age++;
            end
            if (m_pk > 0) led = led | (1 << (m_pk - 1));
        end
        ce.t = n + 2; ce.c = c;
        cq.push_back(ce);
        be.t = n + 3; be.bar = lvl; be.led = led;
        bq.push_back(be);
    endtask

    task automatic do_reset(input int n);
        bev_t be;
        cev_t ce;
        reset = 1'b1;
        sample_valid = 1'b0;
        while (bq.size() > 0 && bq[$].t > cyc) void'(bq.pop_back());
        while (cq.size() > 0 && cq[$].t > cyc) void'(cq.pop_back());
        be.t = cyc + 1; be.bar = 0; be.led = 0;
        bq.push_back(be);
        ce.t = cyc + 1; ce.c = 0;
        cq.push_back(ce);
        m_env = 0; m_nsamp = 0; m_since = 0; m_clipped = 1'b0; m_pk = 0; m_age = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic send(input logic [23:0] d, input int gap);
        sample_valid = 1'b1;
        sample_data  = d;
        model_sample(d, cyc);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_data  = 24'h5A5A5A;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every-cycle comparison of the DUT against the model's time-stamped expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            while (cq.size() > 0 && cq[0].t <= cyc) begin
                e_clip = cq[0].c;
                void'(cq.pop_front());
            end
            while (bq.size() > 0 && bq[0].t <= cyc) begin
                e_bar = bq[0].bar;
                e_led = bq[0].led;
                void'(bq.pop_front());
            end
            check("model_clip", 32'(clip), 32'(e_clip));
            check("model_bar", 32'(bar_level), 32'(e_bar));
            check("model_led", 32'(led_red), 32'(e_led));
        end
    end

    initial begin
        do_reset(2);

        // Full-scale-ish sample, then reset mid-operation.
        send(24'h400000, 2);
        check("t1_led", 32'(led_red), 32'h3FF);
        check("t1_bar", 32'(bar_level), 32'd10);
        check("t1_clip", 32'(clip), 32'd0);
        do_reset(1);
        check("rst_led", 32'(led_red), 32'h000);
        check("rst_bar", 32'(bar_level), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);

        // Lowest step, then saturating negative full scale.
        send(24'hFFE000, 2);
        check("t2_bar", 32'(bar_level), 32'd1);
        check("t2_led", 32'(led_red), 32'h001);
        send(24'h800000, 2);
        check("t2_sat_bar", 32'(bar_level), 32'd10);
        check("t2_sat_clip", 32'(clip), 32'd1);
        do_reset(1);

        // Decay on the 4th sample drops one step.
        send(24'h400000, 2);
        repeat (3) send(24'h000000, 2);
        check("t3_bar", 32'(bar_level), 32'd9);
        check("t3_led", 32'(led_red), PEAK ? 32'h3FF : 32'h1FF);
        repeat (36) send(24'h000000, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("t3_clip", 32'(clip), 32'd0);
        do_reset(1);

        // Clip hold and re-trigger during hold.
        send(24'h7F0000, 2);
        repeat (7) send(24'h000000, 2);
        check("t4_hold7", 32'(clip), 32'd1);
        send(24'h000000, 2);
        check("t4_clear8", 32'(clip), 32'd0);
        send(24'h7F0000, 2);
        repeat (3) send(24'h000000, 2);
        send(24'h7F0000, 2);
        repeat (7) send(24'h000000, 2);
        check("t4_ext7", 32'(clip), 32'd1);
        send(24'h000000, 2);
        check("t4_ext_clear", 32'(clip), 32'd0);
        do_reset(1);

        // Attack coincident with the decay tick, then next tick after wrap.
        send(24'h100000, 2);
        send(24'h000000, 2);
        send(24'h000000, 2);
        send(24'h400000, 2);
        check("t5_attack", 32'(bar_level), 32'd10);
        repeat (3) send(24'h000000, 2);
        check("t5_nodecay", 32'(bar_level), 32'd10);
        send(24'h000000, 2);
        check("t5_wrap_tick", 32'(bar_level), 32'd9);

        // Back-to-back samples at full throughput.
        send(24'h002000, 0);
        send(24'hFFC000, 0);
        send(24'h7F0000, 0);
        send(24'h000000, 0);
        send(24'h800001, 0);
        send(24'h123456, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("t5_b2b_bar", 32'(bar_level), 32'd10);
        check("t5_b2b_clip", 32'(clip), 32'd1);
        do_reset(1);

        // Loud burst then a sustained level-2 signal.
        send(24'h400000, 0);
        repeat (400) send(24'h004000, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_bar", 32'(bar_level), 32'd2);
        check("t6_led", 32'(led_red), 32'h003);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
